// File: rtl/cpu_pkg.sv
// Shared constants for the CPU peripheral slice: default MMIO addresses,
// UART control/status bit positions and the transmitter state encoding.
package cpu_pkg;

  localparam logic [31:0] TXD_ADDR_DEFAULT = 32'h4000_0018;
  localparam logic [31:0] CON_ADDR_DEFAULT = 32'h4000_0020;

  localparam int CON_BUSY  = 0;
  localparam int CON_FULL  = 1;
  localparam int CON_OVF   = 2;
  localparam int CON_IRQEN = 3;
  localparam int CON_DONE  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth, combinational head output and
// an occupancy counter one bit wider than the pointers.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and CON register.
// Define UART_TX_IRQ_EN to enable the CON[3] interrupt enable and irq output.
module uart_tx_periph
  import cpu_pkg::*;
#(
  parameter int          BAUD_DIV   = 5208,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TXD_ADDR   = TXD_ADDR_DEFAULT,
  parameter logic [31:0] CON_ADDR   = CON_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_t        r_state, w_stateNext;
  logic [CNT_W-1:0] r_baudCnt, w_baudCntNext;
  logic [2:0]       r_bitIdx, w_bitIdxNext;
  logic [7:0]       r_shift, w_shiftNext;
  logic             r_txd, w_txdNext;
  logic             r_overflow;
  logic             r_done;
  logic             w_pop;
  logic             w_doneSet;
  logic             w_bitEnd;
  logic             w_txdWrite;
  logic             w_conWrite;
  logic             w_fifoPush;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic [7:0]       w_fifoDout;
  logic             w_irqEn;
  logic [31:0]      w_con;
  logic             w_unused;

  assign w_unused   = ^wdata[31:8];
  assign w_txdWrite = mem_write && (addr == TXD_ADDR);
  assign w_conWrite = mem_write && (addr == CON_ADDR);
  assign w_fifoPush = w_txdWrite && (!w_fifoFull || w_pop);
  assign w_bitEnd   = (r_baudCnt == BAUD_LAST);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_fifoPush),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_fifoDout),
    .full  (w_fifoFull),
    .empty (w_fifoEmpty)
  );

  always_comb begin
    w_stateNext   = r_state;
    w_baudCntNext = r_baudCnt;
    w_bitIdxNext  = r_bitIdx;
    w_shiftNext   = r_shift;
    w_txdNext     = r_txd;
    w_pop         = 1'b0;
    w_doneSet     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop         = 1'b1;
          w_stateNext   = ST_START;
          w_baudCntNext = '0;
          w_shiftNext   = w_fifoDout;
          w_txdNext     = 1'b0;
        end
      end
      ST_START: begin
        if (w_bitEnd) begin
          w_stateNext   = ST_DATA;
          w_baudCntNext = '0;
          w_bitIdxNext  = '0;
          w_txdNext     = r_shift[0];
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bitEnd) begin
          w_baudCntNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = ST_STOP;
            w_txdNext   = 1'b1;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
            w_shiftNext  = r_shift >> 1;
            w_txdNext    = r_shift[1];
          end
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        if (w_bitEnd) begin
          w_baudCntNext = '0;
          w_bitIdxNext  = '0;
          if (!w_fifoEmpty) begin
            w_pop       = 1'b1;
            w_stateNext = ST_START;
            w_shiftNext = w_fifoDout;
            w_txdNext   = 1'b0;
          end else begin
            w_stateNext = ST_IDLE;
            w_doneSet   = 1'b1;
          end
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudCntNext;
      r_bitIdx  <= w_bitIdxNext;
      r_shift   <= w_shiftNext;
      r_txd     <= w_txdNext;
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_txdWrite && w_fifoFull && !w_pop) r_overflow <= 1'b1;
      else if (w_conWrite && wdata[CON_OVF])  r_overflow <= 1'b0;
      if (w_doneSet)                          r_done <= 1'b1;
      else if (w_conWrite && wdata[CON_DONE]) r_done <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irqEn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_irqEn <= 1'b0;
    else if (w_conWrite) r_irqEn <= wdata[CON_IRQEN];
  end

  assign w_irqEn = r_irqEn;
  assign irq     = r_irqEn & r_done;
`else
  assign w_irqEn = 1'b0;
  assign irq     = 1'b0;
`endif

  assign w_con = {27'd0, r_done, w_irqEn, r_overflow, w_fifoFull, (r_state != ST_IDLE)};
  assign rdata = (mem_read && (addr == CON_ADDR)) ? w_con : 32'd0;
  assign txd   = r_txd;

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, clock cycles per serial bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter TXD_ADDR, default 32'h40000018, transmit data register address.
REQ-004 SHALL have parameter CON_ADDR, default 32'h40000020, control/status register address.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n as below.
REQ-006 SHALL have port clk  input  1  system clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous reset, active low.
REQ-008 SHALL have port addr  input  32  MEM-stage byte address (MEM_ALUResult).
REQ-009 SHALL have port wdata  input  32  MEM-stage store data.
REQ-010 SHALL have port mem_read  input  1  load strobe, one cycle per access.
REQ-011 SHALL have port mem_write  input  1  store strobe, one cycle per access.
REQ-012 SHALL have port rdata  output  32  load data, combinational on addr and mem_read.
REQ-013 SHALL have port txd  output  1  serial line, 8N1, idle high.
REQ-014 SHALL have port irq  output  1  level interrupt request to the core.

Function
REQ-015 SHALL push wdata[7:0] into the FIFO on a mem_write to TXD_ADDR when the FIFO is not full.
REQ-016 SHALL drop a write to TXD_ADDR made while the FIFO is full, and SHALL set sticky bit CON[2] (overflow).
REQ-017 SHALL define CON as follows: [0] busy (RO, state≠IDLE); [1] FIFO full (RO); [2] overflow (W1C); [3] irq_enable (RW); [4] tx_done (W1C); [31:5] read 0.
REQ-018 SHALL drive rdata as: CON value when mem_read and addr==CON_ADDR; 0 for any other read or when mem_read=0 (TXD reads return 0).
REQ-019 SHALL implement an FSM with states IDLE, START, DATA, STOP, and registered txd.
REQ-020 SHALL, from IDLE with the FIFO non-empty, pop the head at the next edge, enter START and drive txd=0 (txd falls one cycle after the write edge into an empty idle block).
REQ-021 SHALL hold each bit for exactly BAUD_DIV cycles using a baud counter reloaded on every bit boundary.
REQ-022 SHALL send DATA bits LSB first, 8 bits, using a 3-bit index; then STOP with txd=1 for BAUD_DIV cycles.
REQ-023 SHALL, at STOP end, pop and go straight to START if the FIFO is non-empty (no idle gap, frame = 10*BAUD_DIV cycles); otherwise go to IDLE and set tx_done.
REQ-024 SHALL, on a simultaneous push and pop with the FIFO full, accept the push without setting overflow.
REQ-025 SHALL let set win over a W1C clear that occurs in the same cycle for CON[2] and CON[4].
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH and track occupancy with a count of width clog2(FIFO_DEPTH)+1.
REQ-027 SHALL ignore accesses to all other addresses.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, txd=1, FIFO empty, CON[4:2]=0, baud counter and bit index 0, and irq=0.
REQ-029 SHALL abort any frame in progress when reset asserts mid-frame; txd SHALL return high asynchronously.

Configuration
REQ-030 SHALL, with UART_TX_IRQ_EN defined, drive irq = CON[3] & CON[4].
REQ-031 SHALL, without UART_TX_IRQ_EN, tie irq to 0, make CON[3] read 0, and ignore writes to CON[3].

Structure
REQ-032 SHALL place the default address constants, CON bit indices and the FSM state enum in shared package cpu_pkg.
REQ-033 SHALL implement the FIFO as sub-module sync_fifo (push, pop, full, empty, dout).

Verification
REQ-034 SHALL cover: with BAUD_DIV=4, store 0xA5 to TXD -> txd low 1 cycle later, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, high stop, busy=1 for 40 cycles, then tx_done=1.
REQ-035 SHALL cover: 5 back-to-back stores with FIFO_DEPTH=4 while idle -> 5 frames sent contiguously, overflow=0 (first byte popped before the 5th push).
REQ-036 SHALL cover: 6 stores during one frame -> 4 queued, 5th/6th dropped, CON[2]=1; W1C write 0x4 -> CON[2]=0.
REQ-037 SHALL cover: UART_TX_IRQ_EN defined, CON=0x8, send 1 byte -> irq rises at STOP end; write 0x18 -> irq falls.
REQ-038 SHALL cover: rst_n pulse mid-DATA -> txd=1 immediately, FIFO empty, CON reads 0.
